mc_core: RTL and testbench
==========================

MC_CORE -- requirements
Module: mc_core

Interface
REQ-001 Parameter D, default 12: program counter width.
REQ-002 Parameter W, default 8: datapath and register width.
REQ-003 Parameter RA, default 3: register address width; instruction width IW = 3 + 2*RA; register count 2**RA.
REQ-004 Parameter MAX_PC, default 128: PC value that forces halt.
REQ-005 Ports: clk in 1, sole clock; reset in 1, asynchronous, active-high.
REQ-006 start in 1: begin execution at PC 0 (honoured only in IDLE/HALT).
REQ-007 imem_addr out D: fetch address, always equal to PC; imem_data in IW: combinational instruction return.
REQ-008 dmem_req out 1, dmem_we out 1, dmem_addr out W, dmem_wdata out W, dmem_rdata in W, dmem_ack in 1: data-memory request/acknowledge port.
REQ-009 busy out 1: state not IDLE/HALT; done out 1: state is HALT.

Function
REQ-010 Instruction fields: op = IW-1:IW-3; rA = next RA bits; rB = low RA bits; off = low 2*RA bits, signed.
REQ-011 Opcodes: 000 ADD rA=rA+rB; 001 SUB rA=rA-rB; 010 AND; 011 XOR; 100 LDI rA=zero-extended rB field; 101 LD rA=mem[rB]; 110 ST mem[rB]=rA; 111 BZ: off==0 halts, else branch if Z.
REQ-012 Arithmetic modulo 2**W; carry/borrow discarded.
REQ-013 Z flag updated by ADD/SUB/AND/XOR/LDI/LD to (result==0); unchanged by ST/BZ.
REQ-014 FSM states IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT; one state per cycle except MEM.
REQ-015 IDLE/HALT: start=1 -> PC=0, next FETCH; registers and Z retained.
REQ-016 FETCH latches imem_data into IR; DECODE latches regs rA, rB into operand latches; EXEC computes result/address, LD/ST -> MEM, others -> WB.
REQ-017 MEM: dmem_req=1, dmem_we=1 for ST only, addr/wdata stable; exit to WB on the cycle dmem_ack=1 is sampled; no timeout.
REQ-018 dmem_req deasserts in WB; dmem_ack outside MEM ignored.
REQ-019 WB: register write (ALU/LDI/LD), PC update, then FETCH or HALT.
REQ-020 Latency: ALU/LDI/BZ 4 cycles; LD/ST 4 cycles plus ack-wait cycles (ack in first MEM cycle -> 5).
REQ-021 PC update: BZ taken -> PC + sext(off); otherwise PC+1; modulo 2**D.
REQ-022 BZ off==0 or updated PC==MAX_PC -> HALT; PC holds.
REQ-023 start while busy ignored.

Reset
REQ-024 Reset -> state IDLE, PC=0, IR=0, Z=0, all registers 0, done=0, busy=0, dmem_req=0, dmem_we=0; outputs drop combinationally from reset, including mid-MEM.

Structure
REQ-025 Package mc_core_pkg holds opcode enum and FSM state enum.
REQ-026 Sub-module mc_regfile: 2**RA x W, two combinational read ports, one synchronous write port, async reset.

Verification (W=8, RA=3, D=12)
REQ-027 LDI r1,5; LDI r2,3; ADD r1,r2; BZ 0 -> r1=0x08, Z=0, done=1 with imem_addr=3, 16 cycles after start sampled.
REQ-028 LDI r1,1; LDI r2,1; SUB r1,r2; BZ +3 -> Z=1, imem_addr sequence 0,1,2,3,6; halt at 6 (BZ 0 there).
REQ-029 LDI r1,0; LDI r2,1; SUB r1,r2; ADD r1,r2 -> r1=0xFF then 0x00, Z=1 after ADD.
REQ-030 LDI r1,6; LDI r2,4; ST r1,r2 with ack delayed 3 cycles -> req high 3 cycles, addr=0x04, wdata=0x06, we=1; then LD r3,r2 -> r3=0x06.
REQ-031 reset asserted during MEM wait -> dmem_req=0 same cycle, busy=0, regs 0; later start fetches from imem_addr=0.
REQ-032 128 non-branch instructions -> done=1 with PC=128; start in HALT restarts at 0.

Source files
------------

// File: rtl/mc_core_pkg.sv
// Shared types for the mc_core multi-cycle processor: opcode and FSM state encodings.
package mc_core_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_XOR = 3'b011,
        OP_LDI = 3'b100,
        OP_LD  = 3'b101,
        OP_ST  = 3'b110,
        OP_BZ  = 3'b111
    } opcode_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

endpackage

// File: rtl/mc_core_if.sv
// Instruction-fetch and data-memory buses of mc_core; master is the core, slave the memory side.
interface mc_core_if #(
    parameter int D  = 12,
    parameter int W  = 8,
    parameter int IW = 9
);
    logic [D-1:0]  imem_addr;
    logic [IW-1:0] imem_data;

    // dmem handshake: dmem_req rises with we/addr/wdata valid and holds them stable
    // until the cycle dmem_ack is sampled high; dmem_ack while dmem_req is low means nothing.
    logic          dmem_req;
    logic          dmem_we;
    logic [W-1:0]  dmem_addr;
    logic [W-1:0]  dmem_wdata;
    logic [W-1:0]  dmem_rdata;
    logic          dmem_ack;

    modport master (
        output imem_addr,
        input  imem_data,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );

endinterface

// File: rtl/mc_regfile.sv
// Register file: 2**RA words of W bits, two combinational reads, one synchronous write.
module mc_regfile #(
    parameter int W  = 8,
    parameter int RA = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [RA-1:0] ra_addr,
    input  logic [RA-1:0] rb_addr,
    output logic [W-1:0]  ra_data,
    output logic [W-1:0]  rb_data,
    input  logic          we,
    input  logic [RA-1:0] waddr,
    input  logic [W-1:0]  wdata
);

    logic [W-1:0] regs [2**RA];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2**RA; i++) regs[i] <= '0;
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign ra_data = regs[ra_addr];
    assign rb_data = regs[rb_addr];

endmodule

// File: rtl/mc_core.sv
// Multi-cycle accumulator-style core: FETCH/DECODE/EXEC/[MEM]/WB per instruction,
// halting on BZ with zero offset or when the PC reaches MAX_PC.
module mc_core
    import mc_core_pkg::*;
#(
    parameter int D      = 12,
    parameter int W      = 8,
    parameter int RA     = 3,
    parameter int MAX_PC = 128
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output state_t     dbg_state,
    output logic       dbg_z,
    mc_core_if.master  bus
);

    localparam int IW = 3 + 2*RA;

    state_t          state, state_nxt;
    logic [D-1:0]    pc;
    logic [IW-1:0]   ir;
    logic [W-1:0]    opa, opb, res;
    logic            z;

    opcode_t         op;
    logic [RA-1:0]   ra_f, rb_f;
    logic [2*RA-1:0] off;
    logic [D-1:0]    off_sx, pc_nxt;
    logic [W-1:0]    rf_a, rf_b, alu;
    logic            taken, writes_reg, bz_stop, halt_wb;

    assign op     = opcode_t'(ir[IW-1 -: 3]);
    assign ra_f   = ir[2*RA-1 -: RA];
    assign rb_f   = ir[RA-1:0];
    assign off    = ir[2*RA-1:0];
    assign off_sx = {{(D-2*RA){off[2*RA-1]}}, off};

    assign taken      = (op == OP_BZ) && z;
    assign pc_nxt     = taken ? pc + off_sx : pc + 1'b1;
    assign writes_reg = (op != OP_ST) && (op != OP_BZ);
    // A zero-offset BZ halts with the PC left on the BZ itself.
    assign bz_stop    = (op == OP_BZ) && (off == '0);
    assign halt_wb    = bz_stop || (pc_nxt == D'(MAX_PC));

    mc_regfile #(.W(W), .RA(RA)) u_rf (
        .clk     (clk),
        .reset   (reset),
        .ra_addr (ra_f),
        .rb_addr (rb_f),
        .ra_data (rf_a),
        .rb_data (rf_b),
        .we      ((state == S_WB) && writes_reg),
        .waddr   (ra_f),
        .wdata   (res)
    );

    always_comb begin
        alu = '0;
        case (op)
            OP_ADD:  alu = opa + opb;
            OP_SUB:  alu = opa - opb;
            OP_AND:  alu = opa & opb;
            OP_XOR:  alu = opa ^ opb;
            OP_LDI:  alu = {{(W-RA){1'b0}}, rb_f};
            default: alu = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_HALT: if (start) state_nxt = S_FETCH;
            S_FETCH:        state_nxt = S_DECODE;
            S_DECODE:       state_nxt = S_EXEC;
            S_EXEC:         state_nxt = (op == OP_LD || op == OP_ST) ? S_MEM : S_WB;
            S_MEM:          if (bus.dmem_ack) state_nxt = S_WB;
            S_WB:           state_nxt = halt_wb ? S_HALT : S_FETCH;
            default:        state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            pc    <= '0;
            ir    <= '0;
            opa   <= '0;
            opb   <= '0;
            res   <= '0;
            z     <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE, S_HALT: if (start) pc <= '0;
                S_FETCH:        ir <= bus.imem_data;
                S_DECODE: begin
                    opa <= rf_a;
                    opb <= rf_b;
                end
                S_EXEC:         res <= alu;
                S_MEM:          if (bus.dmem_ack) res <= bus.dmem_rdata;
                S_WB: begin
                    if (writes_reg) z <= (res == '0);
                    if (!bz_stop) pc <= pc_nxt;
                end
                default: ;
            endcase
        end
    end

    // Status and request outputs are gated by reset so they fall in the same cycle.
    assign busy           = !reset && (state != S_IDLE) && (state != S_HALT);
    assign done           = !reset && (state == S_HALT);
    assign bus.dmem_req   = !reset && (state == S_MEM);
    assign bus.dmem_we    = bus.dmem_req && (op == OP_ST);
    assign bus.dmem_addr  = opb;
    assign bus.dmem_wdata = opa;
    assign bus.imem_addr  = pc;
    assign dbg_state      = state;
    assign dbg_z          = z;

endmodule

// File: tb/tb_mc_core.sv
// Bench for mc_core: an instruction-level model predicts fetch order, memory traffic,
// cycle count and final architectural state; a compare process checks every busy cycle.
module tb_mc_core;
    import mc_core_pkg::*;

    localparam int D = 12, W = 8, RA = 3, IW = 9, MAX_PC = 128;

    typedef struct packed {
        logic         we;
        logic [W-1:0] addr;
        logic [W-1:0] wdata;
    } tx_t;

    logic   clk = 1'b0;
    logic   reset;
    logic   start;
    logic   busy, done, dbg_z;
    state_t dbg_state;

    mc_core_if #(.D(D), .W(W), .IW(IW)) bus ();

    mc_core dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state),
        .dbg_z     (dbg_z),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    logic [IW-1:0] imem [2**D];
    logic [W-1:0]  dmem [256];
    assign bus.imem_data = imem[bus.imem_addr];

    // model state
    logic [W-1:0] m_reg [8];
    logic [W-1:0] m_mem [256];
    logic         m_z;
    logic [D-1:0] m_pc;
    int           exp_total;
    logic [D-1:0] exp_pc_q[$];
    tx_t          exp_mem_q[$];
    int           ack_dly_q[$];
    int           dly_plan[$];

    // observation state
    int           n_tests = 0, n_fail = 0;
    bit           chk_on = 0;
    int           cyc, done_cyc, req_len;
    logic [D-1:0] act_pc_q[$];
    int           req_len_q[$];
    bit           have_tx;
    tx_t          first_tx;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [IW-1:0] ins(input int op, input int a, input int b);
        return {3'(op), 3'(a), 3'(b)};
    endfunction

    function automatic logic [IW-1:0] bz(input int off);
        return {3'b111, 6'(off)};
    endfunction

    task automatic clear_low();
        for (int i = 0; i < MAX_PC; i++) imem[i] = bz(0);
    endtask

    task automatic gen_random(input bit with_branch);
        int op;
        for (int i = 0; i < MAX_PC; i++) begin
            op = with_branch ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 6));
            if (op == 7)
                imem[i] = ($urandom_range(0, 15) == 0) ? bz(0) : bz(int'($urandom_range(1, 31)));
            else
                imem[i] = ins(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        end
    endtask

    // Instruction-level interpreter: one loop iteration per instruction.
    task automatic run_model();
        logic [D-1:0]  pc;
        logic [IW-1:0] in;
        logic [W-1:0]  res;
        int            op, a, b, off, dly;
        bit            halt;
        tx_t           t;
        pc = '0; halt = 0; exp_total = 0;
        exp_pc_q.delete(); exp_mem_q.delete(); ack_dly_q.delete();
        for (int s = 0; s < 4000 && !halt; s++) begin
            in  = imem[pc];
            op  = int'(in[8:6]); a = int'(in[5:3]); b = int'(in[2:0]); off = int'(in[5:0]);
            exp_pc_q.push_back(pc);
            exp_total += 4;
            res = '0;
            case (op)
                0: res = m_reg[a] + m_reg[b];
                1: res = m_reg[a] - m_reg[b];
                2: res = m_reg[a] & m_reg[b];
                3: res = m_reg[a] ^ m_reg[b];
                4: res = W'(b);
                5, 6: begin
                    dly = (dly_plan.size() > 0) ? dly_plan.pop_front() : int'($urandom_range(1, 4));
                    ack_dly_q.push_back(dly);
                    exp_total += dly;
                    t.we = (op == 6); t.addr = m_reg[b]; t.wdata = m_reg[a];
                    exp_mem_q.push_back(t);
                    if (op == 6) m_mem[m_reg[b]] = m_reg[a];
                    else         res = m_mem[m_reg[b]];
                end
                default: ;
            endcase
            if (op <= 5) begin
                m_reg[a] = res;
                m_z = (res == '0);
            end
            if (op == 7 && off == 0) halt = 1;
            else begin
                if (op == 7 && m_z) pc = D'(int'(pc) + ((off >= 32) ? off - 64 : off));
                else                pc = pc + 1'b1;
                if (int'(pc) == MAX_PC) halt = 1;
            end
        end
        m_pc = pc;
    endtask

    // Data memory: ack after the planned number of MEM cycles; random ack noise while idle.
    initial begin
        int mem_cnt, cur_dly;
        mem_cnt = 0; cur_dly = 1;
        bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                mem_cnt = 0; bus.dmem_ack = 1'b0;
            end else if (bus.dmem_req) begin
                if (mem_cnt == 0) cur_dly = (ack_dly_q.size() > 0) ? ack_dly_q.pop_front() : 1;
                mem_cnt++;
                if (mem_cnt == cur_dly) begin
                    bus.dmem_ack   = 1'b1;
                    bus.dmem_rdata = dmem[bus.dmem_addr];
                    if (bus.dmem_we) dmem[bus.dmem_addr] = bus.dmem_wdata;
                end else begin
                    bus.dmem_ack   = 1'b0;
                    bus.dmem_rdata = W'($urandom);
                end
            end else begin
                mem_cnt = 0;
                bus.dmem_ack   = ($urandom_range(0, 3) == 0);
                bus.dmem_rdata = W'($urandom);
            end
        end
    end

    // Per-cycle compare against the model while a program runs.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("busy", busy, cyc < exp_total);
            chk("done", done, cyc >= exp_total);
            if (dbg_state == S_FETCH) begin
                act_pc_q.push_back(bus.imem_addr);
                if (exp_pc_q.size() == 0) chk("fetch_extra", bus.imem_addr, 32'hffff_ffff);
                else chk("fetch_pc", bus.imem_addr, exp_pc_q.pop_front());
            end
            if (bus.dmem_req) begin
                req_len++;
                if (!have_tx) begin
                    first_tx = {bus.dmem_we, bus.dmem_addr, bus.dmem_wdata};
                    have_tx = 1;
                end
                if (exp_mem_q.size() == 0) chk("mem_extra", bus.dmem_req, 0);
                else begin
                    chk("mem_we", bus.dmem_we, exp_mem_q[0].we);
                    chk("mem_addr", bus.dmem_addr, exp_mem_q[0].addr);
                    if (exp_mem_q[0].we) chk("mem_wdata", bus.dmem_wdata, exp_mem_q[0].wdata);
                    if (bus.dmem_ack) begin
                        void'(exp_mem_q.pop_front());
                        req_len_q.push_back(req_len);
                        req_len = 0;
                    end
                end
            end
            if (done && done_cyc < 0) done_cyc = cyc;
            if (cyc >= exp_total) chk_on = 0;
            cyc++;
        end
    end

    task automatic run_prog(input int budget);
        run_model();
        cyc = 0; done_cyc = -1; req_len = 0; have_tx = 0;
        act_pc_q.delete(); req_len_q.delete();
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0; chk_on = 1;
        for (int k = 0; k < budget && chk_on; k++) begin
            @(posedge clk); #1;
            start = (cyc + 2 < exp_total) && ($urandom_range(0, 7) == 0);
        end
        start = 1'b0;
        if (chk_on) begin
            chk("run_timeout", 1, 0);
            chk_on = 0;
        end
        @(negedge clk);
        chk("end_pc", bus.imem_addr, m_pc);
        chk("end_z", dbg_z, m_z);
        chk("end_done", done, 1);
        chk("end_pc_q", exp_pc_q.size(), 0);
        chk("end_mem_q", exp_mem_q.size(), 0);
        for (int i = 0; i < 8; i++) chk($sformatf("end_r%0d", i), dut.u_rf.regs[i], m_reg[i]);
    endtask

    initial begin
        int pc_seq[5];
        reset = 1'b1; start = 1'b0;
        for (int i = 0; i < 2**D; i++) imem[i] = bz(0);
        for (int i = 0; i < 256; i++) begin
            dmem[i] = W'($urandom);
            m_mem[i] = dmem[i];
        end
        for (int i = 0; i < 8; i++) m_reg[i] = '0;
        m_z = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_req", bus.dmem_req, 0);
        chk("rst_we", bus.dmem_we, 0);
        chk("rst_pc", bus.imem_addr, 0);
        chk("rst_z", dbg_z, 0);
        chk("rst_state", dbg_state, S_IDLE);
        reset = 1'b0;

        // LDI r1,5; LDI r2,3; ADD r1,r2; BZ 0
        clear_low();
        imem[0] = ins(4, 1, 5); imem[1] = ins(4, 2, 3); imem[2] = ins(0, 1, 2); imem[3] = bz(0);
        run_prog(200);
        chk("t1_r1", dut.u_rf.regs[1], 8'h08);
        chk("t1_z", dbg_z, 0);
        chk("t1_pc", bus.imem_addr, 3);
        chk("t1_latency", done_cyc, 16);

        // LDI r1,1; LDI r2,1; SUB r1,r2; BZ +3; (skipped); BZ 0 at 6
        clear_low();
        imem[0] = ins(4, 1, 1); imem[1] = ins(4, 2, 1); imem[2] = ins(1, 1, 2); imem[3] = bz(3);
        imem[4] = ins(4, 3, 7); imem[5] = ins(4, 3, 7); imem[6] = bz(0);
        run_prog(200);
        pc_seq = '{0, 1, 2, 3, 6};
        chk("t2_z", dbg_z, 1);
        chk("t2_nfetch", act_pc_q.size(), 5);
        for (int i = 0; i < 5 && i < act_pc_q.size(); i++) chk("t2_seq", act_pc_q[i], pc_seq[i]);

        // wraparound: r1 = 0 - 1 stored to mem[1], then + 1 back to zero
        clear_low();
        imem[0] = ins(4, 1, 0); imem[1] = ins(4, 2, 1); imem[2] = ins(1, 1, 2);
        imem[3] = ins(6, 1, 2); imem[4] = ins(0, 1, 2); imem[5] = bz(0);
        run_prog(200);
        chk("t3_mem_ff", dmem[1], 8'hFF);
        chk("t3_r1", dut.u_rf.regs[1], 8'h00);
        chk("t3_z", dbg_z, 1);

        // ST with ack on the third MEM cycle, then LD back
        clear_low();
        imem[0] = ins(4, 1, 6); imem[1] = ins(4, 2, 4); imem[2] = ins(6, 1, 2);
        imem[3] = ins(5, 3, 2); imem[4] = bz(0);
        dly_plan.push_back(3); dly_plan.push_back(1);
        run_prog(200);
        chk("t4_req_len", (req_len_q.size() > 0) ? req_len_q[0] : -1, 3);
        chk("t4_tx", first_tx, {1'b1, 8'h04, 8'h06});
        chk("t4_r3", dut.u_rf.regs[3], 8'h06);

        // reset while waiting for ack
        clear_low();
        imem[0] = ins(4, 1, 5); imem[1] = ins(4, 2, 2); imem[2] = ins(6, 1, 2); imem[3] = bz(0);
        ack_dly_q.delete(); ack_dly_q.push_back(50);
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int k = 0; k < 40 && !bus.dmem_req; k++) @(negedge clk);
        chk("t5_in_mem", bus.dmem_req, 1);
        @(negedge clk); #1;
        reset = 1'b1; #1;
        chk("t5_req", bus.dmem_req, 0);
        chk("t5_we", bus.dmem_we, 0);
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_pc", bus.imem_addr, 0);
        for (int i = 0; i < 8; i++) chk("t5_reg", dut.u_rf.regs[i], 0);
        @(posedge clk); #1; reset = 1'b0;
        ack_dly_q.delete();
        for (int i = 0; i < 8; i++) m_reg[i] = '0;
        m_z = 1'b0;
        gen_random(1);
        run_prog(3000);
        chk("t5_first_fetch", (act_pc_q.size() > 0) ? act_pc_q[0] : 32'hffff, 0);

        // straight-line program runs into MAX_PC
        gen_random(0);
        run_prog(3000);
        chk("t6_maxpc", bus.imem_addr, MAX_PC);

        // restart from HALT with random programs
        for (int r = 0; r < 4; r++) begin
            gen_random(1);
            run_prog(3000);
            chk("restart_pc0", (act_pc_q.size() > 0) ? act_pc_q[0] : 32'hffff, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
